// File: rtl/divider_bcd_out.sv
// Sequential double-dabble converter: quotient and remainder to packed BCD with valid/ack handshake.
// Optional leading-zero blanking outputs are enabled with `define DIVIDER_BCD_BLANK_EN.
module divider_bcd_out #(
  parameter int nBit = 7,
  parameter int NDIG = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [nBit-1:0]     Q,
  input  logic [nBit-1:0]     R,
  input  logic                ack,
  output logic [4*NDIG-1:0]   q_bcd,
  output logic [4*NDIG-1:0]   r_bcd,
  output logic                valid,
  output logic                busy
`ifdef DIVIDER_BCD_BLANK_EN
  ,
  output logic [NDIG-1:0]     q_blank,
  output logic [NDIG-1:0]     r_blank
`endif
);

  localparam int SW = 4 * NDIG;
  localparam int CW = $clog2(nBit + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t          state;
  logic [nBit-1:0] q_bin;
  logic [nBit-1:0] r_bin;
  logic [SW-1:0]   q_scr;
  logic [SW-1:0]   r_scr;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   q_corr;
  logic [SW-1:0]   r_corr;
  logic            capture;

  // Per-digit add-3 correction; digits never carry into each other.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] c;
    c = s;
    for (int i = 0; i < NDIG; i++) begin
      if (s[4*i +: 4] >= 4'd5)
        c[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return c;
  endfunction

`ifdef DIVIDER_BCD_BLANK_EN
  // Bit i set when digit i and every higher digit are zero; the ones digit is never blanked.
  function automatic logic [NDIG-1:0] blank_of(input logic [SW-1:0] d);
    logic [NDIG-1:0] b;
    logic            z;
    b = '0;
    z = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      z    = z & (d[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    return b;
  endfunction
`endif

  assign q_corr  = add3(q_scr);
  assign r_corr  = add3(r_scr);
  // A new conversion is accepted from IDLE, or from DONE when the result is acked on the same edge.
  assign capture = start && ((state == IDLE) || ((state == DONE) && ack));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      q_bin <= '0;
      r_bin <= '0;
      q_scr <= '0;
      r_scr <= '0;
      cnt   <= '0;
      q_bcd <= '0;
      r_bcd <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
`ifdef DIVIDER_BCD_BLANK_EN
      q_blank <= '0;
      r_blank <= '0;
`endif
    end else if (capture) begin
      q_bin <= Q;
      r_bin <= R;
      q_scr <= '0;
      r_scr <= '0;
      cnt   <= CW'(nBit);
      valid <= 1'b0;
      busy  <= 1'b1;
      state <= SHIFT;
    end else begin
      case (state)
        SHIFT: begin
          q_scr <= {q_corr[SW-2:0], q_bin[nBit-1]};
          r_scr <= {r_corr[SW-2:0], r_bin[nBit-1]};
          q_bin <= q_bin << 1;
          r_bin <= r_bin << 1;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1))
            state <= LATCH;
        end
        LATCH: begin
          q_bcd <= q_scr;
          r_bcd <= r_scr;
`ifdef DIVIDER_BCD_BLANK_EN
          q_blank <= blank_of(q_scr);
          r_blank <= blank_of(r_scr);
`endif
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          if (ack) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_bcd_out.sv
// Scoreboard bench for divider_bcd_out: expected BCD values are queued at start and compared when valid rises.
// Define DIVIDER_BCD_BLANK_EN to also check the blanking outputs.
module tb_divider_bcd_out;

  localparam int NBIT = 7;
  localparam int NDIG = 3;
  localparam int SW   = 4 * NDIG;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic            ack = 1'b0;
  logic [NBIT-1:0] q_op = '0;
  logic [NBIT-1:0] r_op = '0;
  logic [SW-1:0]   q_bcd;
  logic [SW-1:0]   r_bcd;
  logic            valid;
  logic            busy;
`ifdef DIVIDER_BCD_BLANK_EN
  logic [NDIG-1:0] q_blank;
  logic [NDIG-1:0] r_blank;
`endif

  int check_count = 0;
  int pass_count  = 0;
  int sb_q[$];
  int sb_r[$];
  int last_q = 0;

  divider_bcd_out #(.nBit(NBIT), .NDIG(NDIG)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Q(q_op),
    .R(r_op),
    .ack(ack),
    .q_bcd(q_bcd),
    .r_bcd(r_bcd),
    .valid(valid),
    .busy(busy)
`ifdef DIVIDER_BCD_BLANK_EN
    ,
    .q_blank(q_blank),
    .r_blank(r_blank)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] to_bcd(input int v);
    logic [SW-1:0] b;
    int rest;
    b = '0;
    rest = v;
    for (int i = 0; i < NDIG; i++) begin
      b[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
    return b;
  endfunction

  function automatic logic [NDIG-1:0] blank_model(input int v);
    logic [NDIG-1:0] b;
    int lim;
    b = '0;
    lim = 1;
    for (int i = 1; i < NDIG; i++) begin
      lim = lim * 10;
      b[i] = (v < lim);
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    check_count++;
    if (got === want) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one start edge; with_ack also acks a pending result on that edge.
  task automatic applyStimulus(input int q, input int r, input bit with_ack);
    q_op  = NBIT'(q);
    r_op  = NBIT'(r);
    start = 1'b1;
    ack   = with_ack;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    sb_q.push_back(q);
    sb_r.push_back(r);
  endtask

  // elapsed = edges already seen since the capture edge; valid must rise at edge 8.
  task automatic waitResult(input int elapsed, input string tag);
    int n;
    bit busy_ok;
    int q;
    int r;
    n = elapsed;
    busy_ok = 1'b1;
    while (!valid && n < 40) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    checkOutput({tag, " latency"}, n, 8);
    checkOutput({tag, " busy during conversion"}, 32'(busy_ok), 1);
    checkOutput({tag, " busy after done"}, 32'(busy), 0);
    if (sb_q.size() == 0) begin
      checkOutput({tag, " scoreboard empty"}, 0, 1);
    end else begin
      q = sb_q.pop_front();
      r = sb_r.pop_front();
      last_q = q;
      checkOutput({tag, " q_bcd"}, 32'(q_bcd), 32'(to_bcd(q)));
      checkOutput({tag, " r_bcd"}, 32'(r_bcd), 32'(to_bcd(r)));
`ifdef DIVIDER_BCD_BLANK_EN
      checkOutput({tag, " q_blank"}, 32'(q_blank), 32'(blank_model(q)));
      checkOutput({tag, " r_blank"}, 32'(r_blank), 32'(blank_model(r)));
`endif
    end
  endtask

  task automatic ackResult(input string tag);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checkOutput({tag, " valid after ack"}, 32'(valid), 0);
    checkOutput({tag, " q_bcd persists"}, 32'(q_bcd), 32'(to_bcd(last_q)));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rq;
    int rr;
    tick();
    tick();
    checkOutput("reset q_bcd", 32'(q_bcd), 0);
    checkOutput("reset r_bcd", 32'(r_bcd), 0);
    checkOutput("reset valid", 32'(valid), 0);
    checkOutput("reset busy", 32'(busy), 0);
    reset = 1'b1;
    tick();

    applyStimulus(100, 0, 1'b0);
    waitResult(0, "q100");
    ackResult("q100");

    applyStimulus(127, 5, 1'b0);
    waitResult(0, "q127");
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      q_op  = NBIT'(i + 30);
      r_op  = NBIT'(i);
      tick();
      start = 1'b0;
      checkOutput("hold valid", 32'(valid), 1);
      checkOutput("hold q_bcd", 32'(q_bcd), 32'h127);
      checkOutput("hold r_bcd", 32'(r_bcd), 32'h005);
    end
    checkOutput("hold busy", 32'(busy), 0);
    ackResult("q127");

    applyStimulus(12, 3, 1'b0);
    waitResult(0, "q12");
    applyStimulus(99, 42, 1'b1);
    checkOutput("b2b valid drop", 32'(valid), 0);
    checkOutput("b2b busy", 32'(busy), 1);
    waitResult(0, "b2b");
    ackResult("b2b");

    applyStimulus(99, 17, 1'b0);
    tick();
    q_op  = NBIT'(42);
    r_op  = NBIT'(1);
    start = 1'b1;
    ack   = 1'b1;
    tick();
    start = 1'b0;
    ack   = 1'b0;
    waitResult(2, "ignore start");
    ackResult("ignore start");

    applyStimulus(88, 11, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    void'(sb_q.pop_back());
    void'(sb_r.pop_back());
    checkOutput("midreset q_bcd", 32'(q_bcd), 0);
    checkOutput("midreset r_bcd", 32'(r_bcd), 0);
    checkOutput("midreset valid", 32'(valid), 0);
    checkOutput("midreset busy", 32'(busy), 0);
    for (int i = 0; i < 12; i++) tick();
    checkOutput("midreset stays idle valid", 32'(valid), 0);
    checkOutput("midreset stays idle busy", 32'(busy), 0);
    applyStimulus(6, 1, 1'b0);
    waitResult(0, "after reset");
    ackResult("after reset");

    applyStimulus(0, 0, 1'b0);
    waitResult(0, "zero");
    ackResult("zero");
    applyStimulus(127, 127, 1'b0);
    waitResult(0, "max");
    ackResult("max");
    applyStimulus(7, 0, 1'b0);
    waitResult(0, "q7");
    ackResult("q7");
    applyStimulus(45, 9, 1'b0);
    waitResult(0, "q45");
    ackResult("q45");
    applyStimulus(105, 10, 1'b0);
    waitResult(0, "q105");
    ackResult("q105");

    for (int i = 0; i < 8; i++) begin
      rq = int'($urandom_range(127, 0));
      rr = int'($urandom_range(127, 0));
      applyStimulus(rq, rr, 1'b0);
      waitResult(0, "random");
      ackResult("random");
    end

    checkOutput("scoreboard drained", 32'(sb_q.size()), 0);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
